// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot / thermometer encoder pipeline.
//   MODE_ONEHOT / MODE_THERMO : the in_mode encoding
//   MAX_OUT_W                 : widest code the encode function can produce
//   encode()                  : value, mode, width -> {err, code}
package onehot_pkg;

  localparam int unsigned MAX_OUT_W = 256;

  typedef enum logic {
    MODE_ONEHOT = 1'b0,
    MODE_THERMO = 1'b1
  } mode_e;

  typedef struct packed {
    logic                 err;
    logic [MAX_OUT_W-1:0] code;
  } enc_t;

  // Out-of-range values give an all-zero code with err set, regardless of mode.
  function automatic enc_t encode(input int unsigned value, input mode_e mode,
                                  input int unsigned width);
    enc_t res;
    res = '0;
    if (value >= width) begin
      res.err = 1'b1;
    end else begin
      for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
        if (mode == MODE_THERMO) res.code[i] = (i <= value);
        else                     res.code[i] = (i == value);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/onehot_fifo2.sv
// Two-entry valid/ready FIFO.
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid, in_ready, in_data    : write side; in_ready is a register
//   out_valid, out_ready, out_data : read side; out_data is the head entry
// Head/tail organisation: the head register always feeds the output directly.
module onehot_fifo2 #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  import onehot_pkg::*;

  logic [1:0]       r_count;
  logic [1:0]       w_count_d;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] w_head_d;
  logic [WIDTH-1:0] r_tail;
  logic [WIDTH-1:0] w_tail_d;
  logic             r_in_ready;
  logic             w_push;
  logic             w_pop;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = (r_count != 2'd0) & out_ready;

  always_comb begin
    w_count_d = r_count;
    w_head_d  = r_head;
    w_tail_d  = r_tail;
    case ({w_push, w_pop})
      // Push and pop together only happen with one entry held: replace head.
      2'b11: w_head_d = in_data;
      2'b01: begin
        w_head_d  = r_tail;
        w_count_d = r_count - 2'd1;
      end
      2'b10: begin
        if (r_count == 2'd0) w_head_d = in_data;
        else                 w_tail_d = in_data;
        w_count_d = r_count + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_count    <= w_count_d;
      r_head     <= w_head_d;
      r_tail     <= w_tail_d;
      // Registered ready: open whenever the next occupancy leaves a free slot.
      r_in_ready <= (w_count_d != 2'd2);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head;

endmodule

// File: rtl/onehot_encoder_pipe.sv
// Binary to one-hot / thermometer encoder with a 2-entry output buffer.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid, in_ready           : input handshake
//   in_bin, in_mode              : value to encode, 0 = one-hot, 1 = thermometer
//   out_valid, out_ready         : output handshake
//   out_code, out_err            : encoded value, out-of-range flag
//   err_clr, err_count           : clear and saturating count of out-of-range beats
// OUT_W must lie in 2..2**BIN_W and not exceed onehot_pkg::MAX_OUT_W.
module onehot_encoder_pipe #(
  parameter int unsigned BIN_W = 4,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_bin,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_code,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);
  import onehot_pkg::*;

  localparam logic [CNT_W-1:0] CntMax = '1;

  enc_t             w_enc;
  logic [OUT_W:0]   w_fifo_in;
  logic [OUT_W:0]   w_fifo_out;
  logic             w_accept;
  logic             w_err_acc;
  logic             w_unused_code;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] w_err_count_d;

  // Encode ahead of the buffer so the FIFO carries finished payloads.
  assign w_enc     = encode(32'(in_bin), mode_e'(in_mode), OUT_W);
  assign w_fifo_in = {w_enc.err, w_enc.code[OUT_W-1:0]};

  if (OUT_W < MAX_OUT_W) begin : g_unused
    assign w_unused_code = ^w_enc.code[MAX_OUT_W-1:OUT_W];
  end else begin : g_full
    assign w_unused_code = 1'b0;
  end

  onehot_fifo2 #(
    .WIDTH(OUT_W + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (w_fifo_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (w_fifo_out)
  );

  assign {out_err, out_code} = w_fifo_out;

  assign w_accept  = in_valid & in_ready;
  assign w_err_acc = w_accept & w_enc.err;

  // A clear coinciding with an erroneous accept counts that beat.
  always_comb begin
    w_err_count_d = r_err_count;
    if (err_clr) begin
      w_err_count_d = w_err_acc ? CNT_W'(1) : '0;
    end else if (w_err_acc && (r_err_count != CntMax)) begin
      w_err_count_d = r_err_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_err_count <= '0;
    else     r_err_count <= w_err_count_d;
  end

  assign err_count = r_err_count;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Directed bench: two encoder instances (16-bit code / 8-bit counter and
// 10-bit code / 2-bit counter) share one stimulus stream. Expected payloads are
// queued at acceptance and checked by an independent output monitor.
module tb_onehot_encoder_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_bin = 4'd0;
  logic       in_mode = 1'b0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_err;
  logic [15:0] a_out_code;
  logic [7:0]  a_err_count;
  logic        b_in_ready, b_out_valid, b_out_err;
  logic [9:0]  b_out_code;
  logic [1:0]  b_err_count;

  always #5 clk = ~clk;

  onehot_encoder_pipe #(.BIN_W(4), .OUT_W(16), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_bin(in_bin),
    .in_mode(in_mode), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_code(a_out_code), .out_err(a_out_err), .err_clr(err_clr), .err_count(a_err_count)
  );

  onehot_encoder_pipe #(.BIN_W(4), .OUT_W(10), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_bin(in_bin),
    .in_mode(in_mode), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_code(b_out_code), .out_err(b_out_err), .err_clr(err_clr), .err_count(b_err_count)
  );

  typedef struct {
    logic [15:0] code;
    logic        err;
    int unsigned acc;
    bit          lat;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        mon_a, mon_b;
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;
  int unsigned cyc = 0;
  int unsigned exp_ea = 0;
  int unsigned exp_eb = 0;
  bit          lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one beat; queue its expected payload and update the counter models.
  task automatic send(input logic [3:0] bin, input logic mode, input logic [15:0] ac,
                      input logic ae, input logic [15:0] bc, input logic be,
                      input logic clr);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in_bin   = bin;
    in_mode  = mode;
    err_clr  = clr;
    @(negedge clk);
    while (!a_in_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    if (!a_in_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", a_in_ready, w);
      in_valid = 1'b0;
      err_clr  = 1'b0;
      return;
    end
    qa.push_back('{ac, ae, cyc, lat_chk});
    qb.push_back('{bc, be, cyc, lat_chk});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    in_bin   = ~bin;
    in_mode  = ~mode;
    if (clr) exp_ea = ae ? 1 : 0;
    else if (ae && exp_ea < 255) exp_ea++;
    if (clr) exp_eb = be ? 1 : 0;
    else if (be && exp_eb < 3) exp_eb++;
    chk("a_err_count", 32'(a_err_count), exp_ea);
    chk("b_err_count", 32'(b_err_count), exp_eb);
  endtask

  // Output monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (a_out_valid && out_ready) begin
        if (qa.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL a_spurious_beat: got code %0h, expected no beat", a_out_code);
        end else begin
          mon_a = qa.pop_front();
          chk("a_out_code", 32'(a_out_code), 32'(mon_a.code));
          chk("a_out_err", 32'(a_out_err), 32'(mon_a.err));
          if (mon_a.lat) chk("a_latency", cyc - mon_a.acc, 1);
        end
      end
      if (b_out_valid && out_ready) begin
        if (qb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL b_spurious_beat: got code %0h, expected no beat", b_out_code);
        end else begin
          mon_b = qb.pop_front();
          chk("b_out_code", 32'(b_out_code), 32'(mon_b.code));
          chk("b_out_err", 32'(b_out_err), 32'(mon_b.err));
          if (mon_b.lat) chk("b_latency", cyc - mon_b.acc, 1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    idle(2);
    chk("rst_a_out_valid", 32'(a_out_valid), 0);
    chk("rst_a_out_code", 32'(a_out_code), 0);
    chk("rst_a_out_err", 32'(a_out_err), 0);
    chk("rst_a_err_count", 32'(a_err_count), 0);
    chk("rst_a_in_ready", 32'(a_in_ready), 0);
    chk("rst_b_in_ready", 32'(b_in_ready), 0);
    rst = 1'b0;
    idle(1);
    chk("post_rst_a_in_ready", 32'(a_in_ready), 1);
    chk("post_rst_b_in_ready", 32'(b_in_ready), 1);

    // One-hot then thermometer, out_ready held high, latency 1.
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    send(4'd0,  1'b0, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);
    send(4'd1,  1'b0, 16'h0002, 1'b0, 16'h0002, 1'b0, 1'b0);
    send(4'd4,  1'b0, 16'h0010, 1'b0, 16'h0010, 1'b0, 1'b0);
    send(4'd8,  1'b0, 16'h0100, 1'b0, 16'h0100, 1'b0, 1'b0);
    send(4'd15, 1'b0, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(4'd0,  1'b1, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);
    send(4'd3,  1'b1, 16'h000F, 1'b0, 16'h000F, 1'b0, 1'b0);
    send(4'd15, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(4'd9,  1'b1, 16'h03FF, 1'b0, 16'h03FF, 1'b0, 1'b0);
    idle(3);

    // Backpressure: two beats fill the buffer, the third waits.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(4'd2, 1'b0, 16'h0004, 1'b0, 16'h0004, 1'b0, 1'b0);
    send(4'd5, 1'b0, 16'h0020, 1'b0, 16'h0020, 1'b0, 1'b0);
    chk("full_a_in_ready", 32'(a_in_ready), 0);
    fork
      send(4'd7, 1'b1, 16'h00FF, 1'b0, 16'h00FF, 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_a_out_valid", 32'(a_out_valid), 1);
          chk("stall_a_out_code", 32'(a_out_code), 32'h0004);
          chk("stall_b_out_code", 32'(b_out_code), 32'h0004);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(4);

    // Reset with two beats buffered.
    out_ready = 1'b0;
    send(4'd12, 1'b0, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(4'd13, 1'b1, 16'h3FFF, 1'b0, 16'h0000, 1'b1, 1'b0);
    rst = 1'b1;
    idle(1);
    chk("midrst_a_out_valid", 32'(a_out_valid), 0);
    chk("midrst_b_out_valid", 32'(b_out_valid), 0);
    chk("midrst_b_err_count", 32'(b_err_count), 0);
    chk("midrst_a_in_ready", 32'(a_in_ready), 0);
    qa.delete();
    qb.delete();
    exp_ea    = 0;
    exp_eb    = 0;
    rst       = 1'b0;
    out_ready = 1'b1;
    idle(1);
    chk("midrst_a_in_ready_up", 32'(a_in_ready), 1);
    idle(3);

    // Out-of-range on the 10-bit instance, then clear coinciding with an error.
    lat_chk = 1'b1;
    send(4'd10, 1'b0, 16'h0400, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(4'd15, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(4'd12, 1'b0, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Saturation of the 2-bit counter.
    send(4'd11, 1'b0, 16'h0800, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(4'd12, 1'b0, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(4'd13, 1'b0, 16'h2000, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(4'd14, 1'b0, 16'h4000, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(4'd15, 1'b0, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) idle(1);
    idle(2);
    chk("drain_a_queue", qa.size(), 0);
    chk("drain_b_queue", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_pipe.md
ONEHOT_ENCODER_PIPE -- requirements
Module: onehot_encoder_pipe

Interface
REQ-001 SHALL have parameter BIN_W, default 4, the binary input width.
REQ-002 SHALL have parameter OUT_W, default 16, the code output width; legal range 2..2**BIN_W.
REQ-003 SHALL have parameter CNT_W, default 8, the error counter width.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the block's only clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  input beat present.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port in_bin  input  BIN_W  binary value to encode.
REQ-009 SHALL have port in_mode  input  1  0 = one-hot, 1 = thermometer; sampled with the beat.
REQ-010 SHALL have port out_valid  output  1  output beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-012 SHALL have port out_code  output  OUT_W  encoded value.
REQ-013 SHALL have port out_err  output  1  beat's input was out of range.
REQ-014 SHALL have port err_clr  input  1  synchronous clear of err_count.
REQ-015 SHALL have port err_count  output  CNT_W  saturating count of out-of-range beats accepted.

Function
REQ-016 SHALL accept a beat on any cycle where in_valid and in_ready are both 1; SHALL deliver a beat on any cycle where out_valid and out_ready are both 1.
REQ-017 SHALL encode one-hot mode as out_code bit in_bin = 1, all other bits 0.
REQ-018 SHALL encode thermometer mode as out_code bits [in_bin:0] = 1, bits above = 0 (in_bin = 0 gives 1 bit set).
REQ-019 SHALL treat in_bin >= OUT_W as out of range: out_code = 0, out_err = 1, in either mode; in-range beats carry out_err = 0.
REQ-020 SHALL buffer accepted beats in a 2-entry FIFO, presenting them in acceptance order.
REQ-021 SHALL present an accepted beat on out_valid the cycle after acceptance when the FIFO was empty (latency 1).
REQ-022 SHALL drive in_ready from a register: 1 when the FIFO holds 0 or 1 entries, 0 when it holds 2; sustained throughput 1 beat/cycle with out_ready held 1.
REQ-023 SHALL, when full, simultaneous accept and deliver not occur (in_ready = 0); when holding 1 entry, simultaneous accept and deliver SHALL keep occupancy at 1.
REQ-024 SHALL hold out_code, out_err stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL increment err_count on each accepted out-of-range beat, saturating at 2**CNT_W-1.
REQ-026 SHALL, when err_clr and an out-of-range acceptance coincide, set err_count to 1; err_clr alone sets 0.
REQ-027 SHALL ignore in_bin and in_mode when in_valid = 0.

Reset
REQ-028 SHALL, on rst = 1 at a clock edge, empty the FIFO and set out_valid = 0, out_code = 0, out_err = 0, err_count = 0, in_ready = 0.
REQ-029 SHALL raise in_ready to 1 the first cycle after rst deasserts.
REQ-030 SHALL discard any buffered beats when rst asserts mid-operation; no beat in flight is delivered after reset.

Structure
REQ-031 SHALL take the mode encoding (MODE_ONEHOT = 0, MODE_THERMO = 1) and the encode function (value, mode, width -> code, err) from shared package onehot_pkg.
REQ-032 SHALL implement the 2-entry buffer as sub-module onehot_fifo2, parametrised by payload width OUT_W+1; encode logic sits before the FIFO.

Verification
REQ-033 SHALL cover: defaults, one-hot mode, in_bin = 0,1,4,8,15 with out_ready = 1 -> out_code = 0x0001,0x0002,0x0010,0x0100,0x8000 each 1 cycle after acceptance, out_err = 0.
REQ-034 SHALL cover: thermometer mode, in_bin = 0,3,15 -> out_code = 0x0001,0x000F,0xFFFF.
REQ-035 SHALL cover: OUT_W = 10, in_bin = 10 and 15 -> out_code = 0, out_err = 1, err_count 0->1->2; then err_clr with a further in_bin = 12 -> err_count = 1.
REQ-036 SHALL cover: out_ready = 0 while 3 beats offered back-to-back -> 2 accepted, in_ready = 0 on third, out_code stable; release out_ready -> beats delivered in order, third then accepted.
REQ-037 SHALL cover: CNT_W = 2, 5 out-of-range beats -> err_count saturates at 3.
REQ-038 SHALL cover: rst asserted with 2 beats buffered -> out_valid = 0, err_count = 0 next cycle, no stale beat delivered, in_ready = 1 one cycle after rst drops.
